image_row_reader: RTL
=====================

Name: image_row_reader

Overview:
- Reads a 40x30 image ROM and streams the image to the VGA pixel path as a sprite.
- Once per scan line it drives the ROM row address. At the sprite's left edge it loads the 480-bit row word, then shifts one 12-bit pixel {R4,G4,B4} out per pixel tick, with optional integer scaling and a transparent key colour.
- Sits between the VGA sync counters and the colour mux that drives the DAC pins.

Parameters:
- IMG_W, 40, image width in pixels; row word width is 12*IMG_W.
- IMG_H, 30, image height in rows.
- SCALE_LOG2, 0, log2 of the integer scale factor S. Legal values are 0, 1 and 2 (S = 1, 2, 4).
- TRANSPARENT, 12'hFFF, pixel value treated as transparent.
- BG_COLOR, 12'h000, value driven on rgb_out when no opaque sprite pixel is active.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_tick  in  1  one-cycle pixel enable; all state advances only on cycles where it is high.
- video_on  in  1  high inside the 640x480 visible area.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- sprite_x  in  10  left edge of the sprite; legal range 1..639.
- sprite_y  in  10  top edge of the sprite.
- rom_rgb  in  12*IMG_W  row word from the ROM, valid combinationally for rom_row. Pixel 0 occupies bits [12*IMG_W-1 -: 12].
- rom_row  out  5  ROM row address.
- rgb_out  out  12  pixel colour.
- sprite_on  out  1  high while rgb_out carries an opaque sprite pixel.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset (asynchronous, any time, including mid-line):
  - state = IDLE, rom_row = 0, rgb_out = BG_COLOR, sprite_on = 0, busy = 0.
  - shift register, col_cnt and rep_cnt are cleared.
- Offsets (10-bit, modulo 1024):
  - rel_x = pixel_x - sprite_x
  - rel_y = pixel_y - sprite_y
- Row fetch: on a pixel_tick with pixel_x == 0:
  - line_hit <= (rel_y < IMG_H*S)
  - if line_hit, rom_row <= rel_y >> SCALE_LOG2; otherwise rom_row holds its value.
- Because line_hit is latched at pixel_x == 0, sprite_x == 0 never starts a line. The sprite is not drawn and sprite_on stays 0.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on a pixel_tick with video_on && line_hit && rel_x == 0:
    - the whole rom_rgb word is loaded into the shift register;
    - pixel 0 is presented on rgb_out on the same edge;
    - col_cnt = 0, rep_cnt = 1 (or rep_cnt wraps to 0 immediately when S = 1).
  - In SHIFT, on each pixel_tick:
    - the current pixel (top 12 bits of the shift register) is presented;
    - rep_cnt increments;
    - when rep_cnt reaches S-1, the shift register shifts left by 12 and col_cnt increments at the end of that tick.
  - SHIFT -> IDLE on the tick that presents the final repetition of pixel IMG_W-1.
  - SHIFT -> IDLE (abort) on any pixel_tick with video_on == 0. That tick drives rgb_out = BG_COLOR and sprite_on = 0. This is how right-edge clipping works.
  - No tick of the FSM re-enters SHIFT mid-line; a new load needs rel_x == 0 on a later line.
- Output rule, registered on every pixel_tick:
  - If the presented pixel exists and is not TRANSPARENT: rgb_out = pixel, sprite_on = 1.
  - Otherwise: rgb_out = BG_COLOR, sprite_on = 0.
  - busy = (next state == SHIFT).
- Latency: the colour for pixel_x = N is valid from the edge after the tick at N until the next tick, i.e. 1 pixel_tick.
- Stall: with pixel_tick low, every register holds its value.
- Sprite width on screen is IMG_W*S ticks, e.g. 40 / 80 / 160.

Test Plan:
- Reset: assert reset mid-SHIFT at sprite column 17, without waiting for a clock edge.
  - Required: rgb_out = 12'h000, sprite_on = 0, busy = 0 and rom_row = 0 immediately.
  - After release: no output until the next line's rel_x == 0.
- Basic draw, S = 1, sprite at (100,50), ROM row 5 = ascending pixel values.
  - Stimulus: pixel_y = 55.
  - Required: rom_row = 5 after the x = 0 tick.
  - Required: sprite_on high after ticks at x = 100..139, with rgb_out equal to row-5 pixels 0..39 in order; low after the x = 140 tick.
- Transparency: row containing 12'hFFF at column 3 and 12'hFBC at column 4.
  - Required: output for x = sprite_x+3 is rgb_out = BG_COLOR, sprite_on = 0.
  - Required: output for x = sprite_x+4 is rgb_out = 12'hFBC, sprite_on = 1.
- Scale, SCALE_LOG2 = 1, sprite at (200,100).
  - Stimulus: pixel_y = 111.
  - Required: rom_row = 5; each pixel held for 2 ticks; busy high for 80 ticks.
  - Required: pixel_y = 160 gives line_hit = 0 and no draw.
- Clipping and stall:
  - sprite_x = 620: 20 pixels are emitted, then video_on falls at x = 640 -> IDLE with sprite_on = 0.
  - Holding pixel_tick low for 5 cycles mid-SHIFT freezes rgb_out and col_cnt.
- Edge: sprite_x = 0 -> sprite_on stays 0 for the entire frame.

Source files
------------

// File: rtl/image_row_reader_if.sv
// Sprite row-reader bus: raster position, sprite placement, ROM row port
// and the registered colour outputs toward the DAC mux.
interface image_row_reader_if #(
    parameter int IMG_W = 40
);
    logic                  pixel_tick;
    logic                  video_on;
    logic [9:0]            pixel_x;
    logic [9:0]            pixel_y;
    logic [9:0]            sprite_x;
    logic [9:0]            sprite_y;
    logic [12*IMG_W-1:0]   rom_rgb;
    logic [4:0]            rom_row;
    logic [11:0]           rgb_out;
    logic                  sprite_on;
    logic                  busy;

    // Sync counters / ROM side
    modport master (
        output pixel_tick, video_on, pixel_x, pixel_y, sprite_x, sprite_y, rom_rgb,
        input  rom_row, rgb_out, sprite_on, busy
    );

    // Row reader side
    modport slave (
        input  pixel_tick, video_on, pixel_x, pixel_y, sprite_x, sprite_y, rom_rgb,
        output rom_row, rgb_out, sprite_on, busy
    );
endinterface

// File: rtl/image_row_reader.sv
// Image row reader: fetches one ROM row per scan line and shifts it out as a
// sprite, one 12-bit pixel per pixel tick, with integer scaling and a
// transparent key colour. All state advances only on pixel_tick.
module image_row_reader #(
    parameter int          IMG_W       = 40,
    parameter int          IMG_H       = 30,
    parameter int          SCALE_LOG2  = 0,
    parameter logic [11:0] TRANSPARENT = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic          clk,
    input  logic          reset,
    image_row_reader_if.slave bus
);
    localparam int S        = 1 << SCALE_LOG2;
    localparam int ROW_BITS = 12 * IMG_W;
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W + 1) : 1;
    localparam int RW       = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [9:0]    SPR_H    = 10'(IMG_H * S);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_REP = RW'(S - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_n;
    logic [ROW_BITS-1:0] sreg, sreg_n, cur_sreg;
    logic [CW-1:0]       col_cnt, col_n, cur_col;
    logic [RW-1:0]       rep_cnt, rep_n, cur_rep;
    logic                line_hit;
    logic [4:0]          rom_row_q;
    logic [11:0]         rgb_q;
    logic                sprite_on_q, busy_q;
    logic [9:0]          rel_x, rel_y;
    logic                start, rep_done, pix_vld;
    logic [11:0]         pix;

    assign rel_x = bus.pixel_x - bus.sprite_x;
    assign rel_y = bus.pixel_y - bus.sprite_y;

    // line_hit seen on the pixel_x == 0 tick still belongs to the previous
    // line, so a left edge at column 0 must never start a load.
    assign start = bus.video_on && line_hit && (rel_x == 10'd0) && (bus.pixel_x != 10'd0);

    assign bus.rom_row   = rom_row_q;
    assign bus.rgb_out   = rgb_q;
    assign bus.sprite_on = sprite_on_q;
    assign bus.busy      = busy_q;

    // Next-state and shift datapath; the load tick is treated as the first
    // SHIFT tick with a fresh row word and zeroed counters.
    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        col_n    = col_cnt;
        rep_n    = rep_cnt;
        pix_vld  = 1'b0;
        cur_sreg = sreg;
        cur_col  = col_cnt;
        cur_rep  = rep_cnt;
        if (state == IDLE) begin
            cur_sreg = bus.rom_rgb;
            cur_col  = '0;
            cur_rep  = '0;
        end
        pix      = cur_sreg[ROW_BITS-1 -: 12];
        rep_done = (cur_rep == LAST_REP);
        if (bus.pixel_tick) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = SHIFT;
                        pix_vld = 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bus.video_on) state_n = IDLE;   // right-edge clip
                    else               pix_vld = 1'b1;
                end
                default: state_n = IDLE;
            endcase
            if (pix_vld) begin
                if (rep_done) begin
                    sreg_n = cur_sreg << 12;
                    col_n  = cur_col + 1'b1;
                    rep_n  = '0;
                    if (cur_col == LAST_COL) state_n = IDLE;
                end else begin
                    sreg_n = cur_sreg;
                    col_n  = cur_col;
                    rep_n  = cur_rep + 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Shift register and column/repeat counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            col_cnt <= '0;
            rep_cnt <= '0;
        end else if (bus.pixel_tick) begin
            sreg    <= sreg_n;
            col_cnt <= col_n;
            rep_cnt <= rep_n;
        end
    end

    // Per-line row fetch at the start of each scan line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_hit  <= 1'b0;
            rom_row_q <= '0;
        end else if (bus.pixel_tick && bus.pixel_x == 10'd0) begin
            line_hit <= (rel_y < SPR_H);
            if (rel_y < SPR_H) rom_row_q <= 5'(rel_y >> SCALE_LOG2);
        end
    end

    // Registered colour output with transparent-key substitution
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q       <= BG_COLOR;
            sprite_on_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.pixel_tick) begin
            if (pix_vld && pix != TRANSPARENT) begin
                rgb_q       <= pix;
                sprite_on_q <= 1'b1;
            end else begin
                rgb_q       <= BG_COLOR;
                sprite_on_q <= 1'b0;
            end
            busy_q <= (state_n == SHIFT);
        end
    end
endmodule
